call_latch: RTL



---
 rtl/call_latch.sv | 120 ++++++++++++
 1 files changed

// File: rtl/call_latch.sv
// Button front end for the elevator controller: synchronise, edge-detect and latch hall/car calls.
// Optional per-bit debounce is built when CALL_DEBOUNCE_EN is defined.
module call_latch #(
  parameter int         DEB_CYCLES  = 8,
  parameter logic [3:0] OPENED_CODE = 4'd7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power,
  input  logic [7:0] up_raw,
  input  logic [7:0] down_raw,
  input  logic [7:0] car_raw,
  input  logic [2:0] floor,
  input  logic [3:0] status,
  output logic [7:0] upcall,
  output logic [7:0] downcall,
  output logic [7:0] floor_btn,
  output logic       any_req
);

  localparam int NB = 24;

  // Packed as {car, down, up}; up at the top floor and down at the bottom floor never latch.
  localparam logic [NB-1:0] VALID_MASK = {8'hFF, 8'hFE, 8'h7F};

  if (DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_bad_deb_cycles
    $error("call_latch: DEB_CYCLES must be in 1..255");
  end

  logic [NB-1:0] raw;
  logic [NB-1:0] s1_q;
  logic [NB-1:0] s2_q;
  logic [NB-1:0] lvl;
  logic [NB-1:0] lvl_d_q;
  logic [NB-1:0] press;
  logic [NB-1:0] req_q;
  logic [NB-1:0] req_d;
  logic [NB-1:0] clr;
  logic [7:0]    clr_floor;
  logic          any_req_q;

  assign raw = {car_raw, down_raw, up_raw};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      lvl_d_q <= '0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      lvl_d_q <= lvl;
    end
  end

`ifdef CALL_DEBOUNCE_EN
  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  logic [NB-1:0] lvl_q;
  logic [7:0]    cnt_q [NB];

  for (genvar b = 0; b < NB; b++) begin : g_deb
    // The counter only runs while the synchronised level disagrees with the accepted level.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q[b] <= '0;
        lvl_q[b] <= 1'b0;
      end else if (s2_q[b] != lvl_q[b]) begin
        if (cnt_q[b] == DEB_LAST) begin
          lvl_q[b] <= s2_q[b];
          cnt_q[b] <= '0;
        end else begin
          cnt_q[b] <= cnt_q[b] + 8'd1;
        end
      end else begin
        cnt_q[b] <= '0;
      end
    end
  end

  assign lvl = lvl_q;
`else
  assign lvl = s2_q;
`endif

  assign press = lvl & ~lvl_d_q;

  always_comb begin
    clr_floor = '0;
    if (status == OPENED_CODE) begin
      clr_floor = 8'h01 << floor;
    end
  end

  assign clr = {3{clr_floor}};

  // Clear beats set, and power-off wipes everything while the input pipeline keeps tracking.
  always_comb begin
    req_d = '0;
    if (power) begin
      req_d = (req_q | press) & ~clr & VALID_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q     <= '0;
      any_req_q <= 1'b0;
    end else begin
      req_q     <= req_d;
      any_req_q <= |req_d;
    end
  end

  assign upcall    = req_q[7:0];
  assign downcall  = req_q[15:8];
  assign floor_btn = req_q[23:16];
  assign any_req   = any_req_q;

endmodule
